// File: rtl/vga_sync_generator.sv
// vga_sync_generator: pixel-tick divider, raster counters, registered sync/display/frame strobes
module vga_sync_generator #(
  parameter int CLK_DIV          = 5,
  parameter int H_ACTIVE         = 640,
  parameter int H_SYNC_START     = 656,
  parameter int H_SYNC_END       = 751,
  parameter int H_TOTAL          = 800,
  parameter int V_ACTIVE         = 480,
  parameter int V_SYNC_START     = 490,
  parameter int V_SYNC_END       = 491,
  parameter int V_TOTAL          = 525,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic       clock_in,
  input  logic       reset_in,
  output logic [9:0] hpos_out,
  output logic [9:0] vpos_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       display_on_out,
  output logic       pixel_tick_out,
  output logic       vsync_start_out,
  output logic [7:0] frame_count_out
);
  localparam logic [9:0] L_DIV_MAX  = 10'(CLK_DIV - 1);
  localparam logic [9:0] L_H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] L_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] L_HS_START = 10'(H_SYNC_START);
  localparam logic [9:0] L_HS_END   = 10'(H_SYNC_END);
  localparam logic [9:0] L_VS_START = 10'(V_SYNC_START);
  localparam logic [9:0] L_VS_END   = 10'(V_SYNC_END);
  localparam logic       L_ON       = SYNC_ACTIVE_HIGH != 0;
  logic [9:0] r_div;
  logic [9:0] w_div_nxt;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic [7:0] w_frame_nxt;
  logic       w_line_end;
  logic       w_frame_end;
  // next divider/counter values; sync and display are derived from these so they track hpos/vpos
  always_comb begin
    w_div_nxt   = (r_div == L_DIV_MAX) ? '0 : r_div + 10'd1;
    w_line_end  = pixel_tick_out && (hpos_out == L_H_MAX);
    w_frame_end = w_line_end && (vpos_out == L_V_MAX);
    w_h_nxt     = !pixel_tick_out ? hpos_out : w_line_end ? '0 : hpos_out + 10'd1;
    w_v_nxt     = !w_line_end ? vpos_out : w_frame_end ? '0 : vpos_out + 10'd1;
    w_frame_nxt = frame_count_out + 8'(w_frame_end);
  end
  // register every output; vsync_start fires only on the tick edge that enters (0, V_SYNC_START)
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_div           <= '0;
      hpos_out        <= '0;
      vpos_out        <= '0;
      frame_count_out <= '0;
      pixel_tick_out  <= 1'b0;
      vsync_start_out <= 1'b0;
      hsync_out       <= ~L_ON;
      vsync_out       <= ~L_ON;
      display_on_out  <= 1'b1;
    end else begin
      r_div           <= w_div_nxt;
      pixel_tick_out  <= w_div_nxt == L_DIV_MAX;
      hpos_out        <= w_h_nxt;
      vpos_out        <= w_v_nxt;
      frame_count_out <= w_frame_nxt;
      vsync_start_out <= pixel_tick_out && (w_h_nxt == '0) && (w_v_nxt == L_VS_START);
      hsync_out       <= (w_h_nxt >= L_HS_START && w_h_nxt <= L_HS_END) ? L_ON : ~L_ON;
      vsync_out       <= (w_v_nxt >= L_VS_START && w_v_nxt <= L_VS_END) ? L_ON : ~L_ON;
      display_on_out  <= (w_h_nxt < L_H_ACT) && (w_v_nxt < L_V_ACT);
    end
  end
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: directed checks of divider, counters, sync, display and frame strobe
module tb_vga_sync_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v, d_h, d_v;
  logic a_hs, a_vs, a_de, a_pt, a_vss;
  logic b_hs, b_vs, b_de, b_pt, b_vss;
  logic c_hs, c_vs, c_de, c_pt, c_vss;
  logic d_hs, d_vs, d_de, d_pt, d_vss;
  logic [7:0] a_fc, b_fc, c_fc, d_fc;

  vga_sync_generator #(.CLK_DIV(1)) u_a (
    .clock_in(clk), .reset_in(rst), .hpos_out(a_h), .vpos_out(a_v), .hsync_out(a_hs),
    .vsync_out(a_vs), .display_on_out(a_de), .pixel_tick_out(a_pt),
    .vsync_start_out(a_vss), .frame_count_out(a_fc));

  vga_sync_generator #(.CLK_DIV(5)) u_b (
    .clock_in(clk), .reset_in(rst), .hpos_out(b_h), .vpos_out(b_v), .hsync_out(b_hs),
    .vsync_out(b_vs), .display_on_out(b_de), .pixel_tick_out(b_pt),
    .vsync_start_out(b_vss), .frame_count_out(b_fc));

  vga_sync_generator #(.CLK_DIV(1), .H_ACTIVE(8), .H_SYNC_START(10), .H_SYNC_END(11), .H_TOTAL(16),
    .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_END(8), .V_TOTAL(10), .SYNC_ACTIVE_HIGH(0)) u_c (
    .clock_in(clk), .reset_in(rst), .hpos_out(c_h), .vpos_out(c_v), .hsync_out(c_hs),
    .vsync_out(c_vs), .display_on_out(c_de), .pixel_tick_out(c_pt),
    .vsync_start_out(c_vss), .frame_count_out(c_fc));

  vga_sync_generator #(.CLK_DIV(3), .H_ACTIVE(8), .H_SYNC_START(10), .H_SYNC_END(11), .H_TOTAL(16),
    .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_END(8), .V_TOTAL(10), .SYNC_ACTIVE_HIGH(1)) u_d (
    .clock_in(clk), .reset_in(rst), .hpos_out(d_h), .vpos_out(d_v), .hsync_out(d_hs),
    .vsync_out(d_vs), .display_on_out(d_de), .pixel_tick_out(d_pt),
    .vsync_start_out(d_vss), .frame_count_out(d_fc));

  // leaves the bench at the negedge of cycle 0 (first cycle after release)
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [33:0] rv;
    do_reset();
    rv = {a_h, a_v, a_hs, a_vs, a_de, a_pt, a_vss, a_fc};
    checks++;
    if (rv !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL reset_state got %h want %h", rv, {10'd0, 10'd0, 5'b00100, 8'd0});
    end
    checks++;
    if ({c_hs, c_vs} !== 2'b11) begin errors++; $display("FAIL reset_sync_low got %b want 11", {c_hs, c_vs}); end
    @(negedge clk);
    checks++;
    if ({a_pt, a_h} !== {1'b1, 10'd0}) begin errors++; $display("FAIL first_tick pt/h got %b/%0d want 1/0", a_pt, a_h); end
    @(negedge clk);
    checks++;
    if (a_h !== 10'd1) begin errors++; $display("FAIL count1 got %0d want 1", a_h); end
    repeat (299) @(negedge clk);
    checks++;
    if (a_h !== 10'd300) begin errors++; $display("FAIL count300 got %0d want 300", a_h); end
    #2 rst = 1'b1;
    #1;
    rv = {a_h, a_v, a_hs, a_vs, a_de, a_pt, a_vss, a_fc};
    checks++;
    if (rv !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL async_reset got %h want %h", rv, {10'd0, 10'd0, 5'b00100, 8'd0});
    end
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_pt, a_h} !== {1'b1, 10'd0}) begin errors++; $display("FAIL post_reset pt/h got %b/%0d want 1/0", a_pt, a_h); end
    @(negedge clk);
    checks++;
    if (a_h !== 10'd1) begin errors++; $display("FAIL post_reset_count got %0d want 1", a_h); end
  endtask

  task automatic test_hline();
    int pos_err = 0, hs_err = 0, de_err = 0, hs_cnt = 0, de_cnt = 0, hs_first = -1;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 800; i++) begin
      if (a_h !== 10'(i) || a_v !== 10'd0) pos_err++;
      if (a_hs !== (i >= 656 && i <= 751)) hs_err++;
      if (a_de !== (i < 640)) de_err++;
      if (a_hs === 1'b1 && hs_first < 0) hs_first = i;
      hs_cnt += int'(a_hs === 1'b1);
      de_cnt += int'(a_de === 1'b1);
      @(negedge clk);
    end
    checks++;
    if (pos_err != 0) begin errors++; $display("FAIL line_pos errs %0d want 0", pos_err); end
    checks++;
    if (hs_cnt != 96) begin errors++; $display("FAIL hsync_width got %0d want 96", hs_cnt); end
    checks++;
    if (hs_first != 656) begin errors++; $display("FAIL hsync_start got %0d want 656", hs_first); end
    checks++;
    if (hs_err != 0) begin errors++; $display("FAIL hsync_level errs %0d want 0", hs_err); end
    checks++;
    if (de_cnt != 640 || de_err != 0) begin errors++; $display("FAIL display_line cnt %0d errs %0d want 640/0", de_cnt, de_err); end
    checks++;
    if ({a_h, a_v} !== {10'd0, 10'd1}) begin errors++; $display("FAIL h_wrap got %0d,%0d want 0,1", a_h, a_v); end
  endtask

  task automatic test_divider();
    int pt_err = 0, h_err = 0, first = -1;
    do_reset();
    for (int k = 0; k < 50; k++) begin
      if (b_pt !== (k % 5 == 4)) pt_err++;
      if (b_h !== 10'(k / 5)) h_err++;
      if (b_pt === 1'b1 && first < 0) first = k;
      @(negedge clk);
    end
    checks++;
    if (pt_err != 0) begin errors++; $display("FAIL div_tick errs %0d want 0", pt_err); end
    checks++;
    if (h_err != 0) begin errors++; $display("FAIL div_hpos errs %0d want 0", h_err); end
    checks++;
    if (first != 4) begin errors++; $display("FAIL div_first_tick got cycle %0d want 4", first); end
  endtask

  task automatic test_small_frame();
    int err = 0, vs_cnt = 0, de_cnt = 0, h, v;
    do_reset();
    @(negedge clk);
    for (int t = 0; t < 160; t++) begin
      h = t % 16;
      v = t / 16;
      if (c_h !== 10'(h) || c_v !== 10'(v) || c_fc !== 8'd0) err++;
      if (c_hs !== !(h >= 10 && h <= 11) || c_vs !== !(v >= 7 && v <= 8)) err++;
      if (c_de !== (h < 8 && v < 6) || c_vss !== (h == 0 && v == 7)) err++;
      vs_cnt += int'(c_vs === 1'b0);
      de_cnt += int'(c_de === 1'b1);
      @(negedge clk);
    end
    checks++;
    if (err != 0) begin errors++; $display("FAIL small_frame errs %0d want 0", err); end
    checks++;
    if (vs_cnt != 32) begin errors++; $display("FAIL vsync_width got %0d want 32", vs_cnt); end
    checks++;
    if (de_cnt != 48) begin errors++; $display("FAIL display_frame got %0d want 48", de_cnt); end
    checks++;
    if ({c_h, c_v, c_fc} !== {10'd0, 10'd0, 8'd1}) begin errors++; $display("FAIL frame_wrap got %0d,%0d fc %0d want 0,0 fc 1", c_h, c_v, c_fc); end
    repeat (40959 - 160) @(negedge clk);
    checks++;
    if ({c_h, c_v, c_fc} !== {10'd15, 10'd9, 8'd255}) begin errors++; $display("FAIL frame_255 got %0d,%0d fc %0d want 15,9 fc 255", c_h, c_v, c_fc); end
    @(negedge clk);
    checks++;
    if ({c_h, c_v, c_fc} !== {10'd0, 10'd0, 8'd0}) begin errors++; $display("FAIL fc_wrap got %0d,%0d fc %0d want 0,0 fc 0", c_h, c_v, c_fc); end
  endtask

  task automatic test_vsync_start();
    int err = 0, pos_err = 0, pulses = 0, first = -1, last = -1;
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (d_vss !== (k > 0 && k % 3 == 0 && (k / 3) % 160 == 112)) err++;
      if (d_vss === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        last = k;
        if (d_h !== 10'd0 || d_v !== 10'd7 || d_vs !== 1'b1) pos_err++;
      end
      @(negedge clk);
    end
    checks++;
    if (err != 0) begin errors++; $display("FAIL vss_timing errs %0d want 0", err); end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL vss_count got %0d want 3", pulses); end
    checks++;
    if (pos_err != 0) begin errors++; $display("FAIL vss_pos errs %0d want 0", pos_err); end
    checks++;
    if (first != 336 || last - first != 960) begin errors++; $display("FAIL vss_spacing first %0d span %0d want 336/960", first, last - first); end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_divider();
    test_small_frame();
    test_vsync_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
